pgm_sched: RTL

Generation scheduler for the packet generator read path. It sequences per-packet replay of the stored template: it decides when each packet starts, which packets are latency probes, enforces the inter-packet gap and the total packet count, and signals completion. It sits between the software configuration path and the template-RAM reader, and replaces free-running start/finish flags with a handshaked, rate-paced schedule.

---
 rtl/pgm_pkg.sv | 20 ++
 rtl/pgm_sched_regs.sv | 76 +++++++
 rtl/pgm_sched.sv | 87 ++++++++
 3 files changed

// File: rtl/pgm_pkg.sv
// pgm_pkg: shared state encoding, register map and STATUS layout for pgm_sched
package pgm_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_SEND  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;
  localparam logic [31:0] A_CTRL      = 32'h0;
  localparam logic [31:0] A_PKT_TOTAL = 32'h1;
  localparam logic [31:0] A_GAP       = 32'h2;
  localparam logic [31:0] A_PROBE_INT = 32'h3;
  localparam logic [31:0] A_STATUS    = 32'h4;
  localparam logic [31:0] A_SENT_CNT  = 32'h5;
  localparam logic [31:0] A_PROBE_CNT = 32'h6;
  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int ST_ERR_BIT = 3;
endpackage

// File: rtl/pgm_sched_regs.sv
// pgm_sched_regs: config registers, per-run shadow copies and registered read mux
module pgm_sched_regs
  import pgm_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int CFG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wr,
  input  logic              cfg_rd,
  input  logic [CFG_AW-1:0] cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic [31:0]       cfg_rdata,
  output logic              cfg_rvalid,
  input  logic              load,
  input  logic              set_err,
  input  state_t            state,
  input  logic [CNT_W-1:0]  sent_cnt,
  input  logic [CNT_W-1:0]  probe_cnt,
  output logic              start_req,
  output logic              stop_req,
  output logic [CNT_W-1:0]  sh_total,
  output logic [CNT_W-1:0]  sh_gap,
  output logic [CNT_W-1:0]  sh_pint
);
  logic [CNT_W-1:0] pkt_total, gap, probe_int;
  logic [31:0] addr, rd_mux;
  logic start_err, ctrl_wr;
  assign addr = 32'(cfg_addr);
  assign ctrl_wr = cfg_wr && addr == A_CTRL;
  always_comb begin
    rd_mux = '1;
    case (addr)
      A_CTRL:      rd_mux = '0;
      A_PKT_TOTAL: rd_mux = 32'(pkt_total);
      A_GAP:       rd_mux = 32'(gap);
      A_PROBE_INT: rd_mux = 32'(probe_int);
      A_STATUS:    rd_mux = 32'(state) | (32'(start_err) << ST_ERR_BIT);
      A_SENT_CNT:  rd_mux = 32'(sent_cnt);
      A_PROBE_CNT: rd_mux = 32'(probe_cnt);
      default:     rd_mux = '1;
    endcase
  end
  // Strobes are registered, which gives the two-cycle write-to-gen_start latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_total  <= '0;
      gap        <= '0;
      probe_int  <= '0;
      sh_total   <= '0;
      sh_gap     <= '0;
      sh_pint    <= '0;
      start_err  <= 1'b0;
      start_req  <= 1'b0;
      stop_req   <= 1'b0;
      cfg_rdata  <= '0;
      cfg_rvalid <= 1'b0;
    end else begin
      start_req  <= ctrl_wr && cfg_wdata[CTRL_START];
      stop_req   <= ctrl_wr && cfg_wdata[CTRL_STOP];
      cfg_rvalid <= cfg_rd;
      if (cfg_rd) cfg_rdata <= rd_mux;
      if (cfg_wr && addr == A_PKT_TOTAL) pkt_total <= CNT_W'(cfg_wdata);
      if (cfg_wr && addr == A_GAP) gap <= CNT_W'(cfg_wdata);
      if (cfg_wr && addr == A_PROBE_INT) probe_int <= CNT_W'(cfg_wdata);
      if (set_err) start_err <= 1'b1;
      else if (ctrl_wr && !cfg_wdata[CTRL_START]) start_err <= 1'b0;
      if (load) begin
        sh_total <= pkt_total;
        sh_gap   <= gap;
        sh_pint  <= probe_int;
      end
    end
  end
endmodule

// File: rtl/pgm_sched.sv
// pgm_sched: paces per-packet template replay with gap, probe marking, packet count and stop
module pgm_sched
  import pgm_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int CFG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wr,
  input  logic              cfg_rd,
  input  logic [CFG_AW-1:0] cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic [31:0]       cfg_rdata,
  output logic              cfg_rvalid,
  input  logic              tpl_ready,
  input  logic              in_rd_alf,
  output logic              gen_start,
  output logic              gen_probe,
  output logic              gen_last,
  input  logic              gen_done,
  output logic              gen_busy,
  output logic              gen_finish
);
  state_t state, nxt;
  logic [CNT_W-1:0] sent_cnt, probe_cnt, phase, gap_cnt, sh_total, sh_gap, sh_pint;
  logic start_req, stop_req, stop_pend, probe_q, last_q;
  logic load, set_err, stop_now, done_ev;
  pgm_sched_regs #(.CNT_W(CNT_W), .CFG_AW(CFG_AW)) u_regs (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_rd(cfg_rd), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cfg_rvalid(cfg_rvalid),
    .load(load), .set_err(set_err), .state(state), .sent_cnt(sent_cnt),
    .probe_cnt(probe_cnt), .start_req(start_req), .stop_req(stop_req),
    .sh_total(sh_total), .sh_gap(sh_gap), .sh_pint(sh_pint)
  );
  // A lost template is treated like a stop: finish at the next packet boundary.
  assign stop_now   = stop_req || stop_pend || !tpl_ready;
  assign load       = state == S_IDLE && start_req && tpl_ready;
  assign set_err    = state == S_IDLE && start_req && !tpl_ready;
  assign done_ev    = state == S_SEND && gen_done;
  assign gen_start  = state == S_ISSUE && !in_rd_alf && !stop_now;
  assign gen_probe  = gen_start && sh_pint != '0 && phase == sh_pint - CNT_W'(1);
  assign gen_last   = gen_start && sh_total != '0 && sent_cnt + CNT_W'(1) == sh_total;
  assign gen_busy   = state != S_IDLE;
  assign gen_finish = state == S_DONE;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = load ? S_ISSUE : S_IDLE;
      S_ISSUE: nxt = stop_now ? S_DONE : in_rd_alf ? S_ISSUE : S_SEND;
      S_SEND:  nxt = !gen_done ? S_SEND : (last_q || stop_now) ? S_DONE : sh_gap == '0 ? S_ISSUE : S_GAP;
      S_GAP:   nxt = stop_now ? S_DONE : gap_cnt == CNT_W'(1) ? S_ISSUE : S_GAP;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sent_cnt  <= '0;
      probe_cnt <= '0;
      phase     <= '0;
      gap_cnt   <= '0;
      stop_pend <= 1'b0;
      probe_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state <= nxt;
      if (load) begin
        sent_cnt  <= '0;
        probe_cnt <= '0;
        phase     <= '0;
        stop_pend <= 1'b0;
      end
      if (gen_start) begin
        probe_q <= gen_probe;
        last_q  <= gen_last;
        phase   <= gen_probe ? '0 : phase + CNT_W'(1);
      end
      if (done_ev) begin
        sent_cnt  <= sent_cnt + CNT_W'(1);
        probe_cnt <= probe_cnt + CNT_W'(probe_q);
      end
      if (state == S_SEND && stop_req) stop_pend <= 1'b1;
      gap_cnt <= (done_ev && nxt == S_GAP) ? sh_gap : state == S_GAP ? gap_cnt - CNT_W'(1) : gap_cnt;
    end
  end
endmodule
